// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, result class encoding and
// the canonical quiet-NaN fields used when packing the result word.
package fpu_pkg;

  localparam int FLG_W = 5;

  // out_flags layout {nan, inf, overflow, underflow, zero}
  localparam int FLG_ZERO = 0;
  localparam int FLG_UNF  = 1;
  localparam int FLG_OVF  = 2;
  localparam int FLG_INF  = 3;
  localparam int FLG_NAN  = 4;

  // sticky_flags layout {invalid, overflow, underflow, inexact, zero}
  localparam int STK_ZERO    = 0;
  localparam int STK_INEXACT = 1;
  localparam int STK_UNF     = 2;
  localparam int STK_OVF     = 3;
  localparam int STK_INVALID = 4;

  typedef enum logic [2:0] {
    CLS_NAN  = 3'd0,
    CLS_INF  = 3'd1,
    CLS_OVF  = 3'd2,
    CLS_UNF  = 3'd3,
    CLS_ZERO = 3'd4,
    CLS_NORM = 3'd5
  } res_class_t;

  // Canonical quiet NaN: positive sign, all-ones exponent, only the frac MSB set.
  localparam logic QNAN_SIGN  = 1'b0;
  localparam logic QNAN_QUIET = 1'b1;

  // Maps a result's flag word onto the sticky accumulator layout.
  function automatic logic [FLG_W-1:0] sticky_bits(input logic [FLG_W-1:0] flags,
                                                   input logic               inexact);
    logic [FLG_W-1:0] s;
    s              = '0;
    s[STK_INVALID] = flags[FLG_NAN];
    s[STK_OVF]     = flags[FLG_OVF];
    s[STK_UNF]     = flags[FLG_UNF];
    s[STK_INEXACT] = inexact;
    s[STK_ZERO]    = flags[FLG_ZERO];
    return s;
  endfunction

endpackage

// File: rtl/fp_result_flag_unit_if.sv
// Bus bundle for fp_result_flag_unit: input result, output word and the
// sticky-flag status port.
interface fp_result_flag_unit_if
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
);

  // Both sides use plain valid/ready: a word moves on a rising edge where
  // valid and ready are both high; a producer holding valid keeps its data
  // stable until that edge, and ready may depend combinationally on the
  // consumer side but never on valid.
  logic                   in_valid;
  logic                   in_ready;
  logic                   res_s;
  logic [MAN_W-1:0]       res_m;
  logic [EXP_W+1:0]       res_e;
  logic                   initial_zero_flag;
  logic                   initial_inf_flag;
  logic                   initial_nan_flag;
  logic                   in_inexact;

  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W-1:0] out_result;
  logic [FLG_W-1:0]       out_flags;
  logic                   out_inexact;

  logic                   clr_sticky;
  logic [FLG_W-1:0]       sticky_flags;

  modport master (
    output in_valid, res_s, res_m, res_e,
           initial_zero_flag, initial_inf_flag, initial_nan_flag, in_inexact,
           out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_flags, out_inexact, sticky_flags
  );

  modport slave (
    input  in_valid, res_s, res_m, res_e,
           initial_zero_flag, initial_inf_flag, initial_nan_flag, in_inexact,
           out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_flags, out_inexact, sticky_flags
  );

endinterface

// File: rtl/fp_result_classify.sv
// Combinational classification of a rounded result into NaN/Inf/Overflow/
// Zero/Underflow/Normal, plus IEEE-754 packing and per-result flags.
module fp_result_classify
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input  logic                   res_s,
  input  logic [MAN_W-1:0]       res_m,
  input  logic [EXP_W+1:0]       res_e,
  input  logic                   zero_in,
  input  logic                   inf_in,
  input  logic                   nan_in,
  input  logic                   inexact_in,
  output logic [EXP_W+MAN_W-1:0] result,
  output logic [FLG_W-1:0]       flags,
  output logic                   inexact
);

  localparam logic [EXP_W+1:0] E_OVF_MIN = {2'b00, {EXP_W{1'b1}}};

  res_class_t cls;
  logic       e_neg;
  logic       e_ovf;
  logic       e_unf;

  // res_e is two's complement: the MSB alone marks a negative exponent.
  assign e_neg = res_e[EXP_W+1];
  assign e_ovf = !e_neg && (res_e >= E_OVF_MIN);
  assign e_unf = e_neg || (res_e == '0);

  always_comb begin
    if (nan_in)                        cls = CLS_NAN;
    else if (inf_in)                   cls = CLS_INF;
    else if (zero_in || res_m == '0)   cls = CLS_ZERO;
    else if (e_ovf)                    cls = CLS_OVF;
    else if (e_unf)                    cls = CLS_UNF;
    else                               cls = CLS_NORM;
  end

  always_comb begin
    result  = '0;
    flags   = '0;
    inexact = 1'b0;
    case (cls)
      CLS_NAN: begin
        result         = {QNAN_SIGN, {EXP_W{1'b1}}, QNAN_QUIET, {(MAN_W-2){1'b0}}};
        flags[FLG_NAN] = 1'b1;
      end
      CLS_INF: begin
        result         = {res_s, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        flags[FLG_INF] = 1'b1;
      end
      CLS_OVF: begin
        result         = {res_s, {EXP_W{1'b1}}, {(MAN_W-1){1'b0}}};
        flags[FLG_INF] = 1'b1;
        flags[FLG_OVF] = 1'b1;
        inexact        = 1'b1;
      end
      CLS_UNF: begin
        // Flush-to-zero: no subnormal encoding is produced.
        result          = {res_s, {EXP_W{1'b0}}, {(MAN_W-1){1'b0}}};
        flags[FLG_UNF]  = 1'b1;
        flags[FLG_ZERO] = 1'b1;
        inexact         = 1'b1;
      end
      CLS_ZERO: begin
        result          = {res_s, {EXP_W{1'b0}}, {(MAN_W-1){1'b0}}};
        flags[FLG_ZERO] = 1'b1;
      end
      default: begin
        result  = {res_s, res_e[EXP_W-1:0], res_m[MAN_W-2:0]};
        inexact = inexact_in;
      end
    endcase
  end

endmodule

// File: rtl/fp_result_flag_unit.sv
// Result classification/flag stage with one registered valid/ready output.
// Optional sticky exception accumulator enabled by FPU_STICKY_FLAGS_EN.
module fp_result_flag_unit
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24
) (
  input logic                  CLK,
  input logic                  RST,
  fp_result_flag_unit_if.slave bus
);

  localparam int RES_W = EXP_W + MAN_W;

  logic [RES_W-1:0] cls_result;
  logic [FLG_W-1:0] cls_flags;
  logic             cls_inexact;

  logic             out_valid_q;
  logic [RES_W-1:0] out_result_q;
  logic [FLG_W-1:0] out_flags_q;
  logic             out_inexact_q;

  logic             in_ready;
  logic             out_fire;

  fp_result_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_classify (
    .res_s      (bus.res_s),
    .res_m      (bus.res_m),
    .res_e      (bus.res_e),
    .zero_in    (bus.initial_zero_flag),
    .inf_in     (bus.initial_inf_flag),
    .nan_in     (bus.initial_nan_flag),
    .inexact_in (bus.in_inexact),
    .result     (cls_result),
    .flags      (cls_flags),
    .inexact    (cls_inexact)
  );

  assign in_ready = bus.out_ready | ~out_valid_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // When ready the register either loads a new word or drops valid (bubble);
  // data is only rewritten on a real transfer so it persists across bubbles.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_valid_q   <= 1'b0;
      out_result_q  <= '0;
      out_flags_q   <= '0;
      out_inexact_q <= 1'b0;
    end else if (in_ready) begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_result_q  <= cls_result;
        out_flags_q   <= cls_flags;
        out_inexact_q <= cls_inexact;
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_flags   = out_flags_q;
  assign bus.out_inexact = out_inexact_q;

`ifdef FPU_STICKY_FLAGS_EN
  logic [FLG_W-1:0] sticky_q;

  // Clear takes effect before the OR, so a same-cycle clear keeps only the
  // word that is transferring.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sticky_q <= '0;
    end else if (out_fire) begin
      sticky_q <= (bus.clr_sticky ? '0 : sticky_q) | sticky_bits(out_flags_q, out_inexact_q);
    end else if (bus.clr_sticky) begin
      sticky_q <= '0;
    end
  end

  assign bus.sticky_flags = sticky_q;
`else
  logic unused_sticky_inputs;
  assign unused_sticky_inputs = bus.clr_sticky ^ out_fire;
  assign bus.sticky_flags     = '0;
`endif

endmodule

// File: tb/tb_fp_result_flag_unit.sv
// Directed self-checking bench for fp_result_flag_unit (EXP_W=8, MAN_W=24).
`timescale 1ns/1ps
module tb_fp_result_flag_unit;

  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int RES_W = EXP_W + MAN_W;
`ifdef FPU_STICKY_FLAGS_EN
  localparam logic STICKY_EN = 1'b1;
`else
  localparam logic STICKY_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [RES_W-1:0] exp_q[$];

  fp_result_flag_unit_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus();

  fp_result_flag_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic s, input logic [MAN_W-1:0] m, input logic [EXP_W+1:0] e,
                            input logic z, input logic inf, input logic nan, input logic inx);
    bus.in_valid          = 1'b1;
    bus.res_s             = s;
    bus.res_m             = m;
    bus.res_e             = e;
    bus.initial_zero_flag = z;
    bus.initial_inf_flag  = inf;
    bus.initial_nan_flag  = nan;
    bus.in_inexact        = inx;
  endtask

  task automatic drive_idle();
    bus.in_valid          = 1'b0;
    bus.res_s             = 1'b0;
    bus.res_m             = '0;
    bus.res_e             = '0;
    bus.initial_zero_flag = 1'b0;
    bus.initial_inf_flag  = 1'b0;
    bus.initial_nan_flag  = 1'b0;
    bus.in_inexact        = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle();
    bus.out_ready  = 1'b1;
    bus.clr_sticky = 1'b0;
    repeat (3) step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_result !== 32'h0) $display("FAIL reset_out_result: got %h expected 00000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b0) $display("FAIL reset_out_flags: got %b expected 00000", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b0) $display("FAIL reset_out_inexact: got %b expected 0", bus.out_inexact); else n_pass++;
    n_checks++; if (bus.sticky_flags !== 5'b0) $display("FAIL reset_sticky: got %b expected 00000", bus.sticky_flags); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_normal();
    drive_word(1'b0, 24'hC00000, 10'h07F, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL normal_valid: got %b expected 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_result !== 32'h3FC00000) $display("FAIL normal_result: got %h expected 3fc00000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00000) $display("FAIL normal_flags: got %b expected 00000", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b1) $display("FAIL normal_inexact: got %b expected 1", bus.out_inexact); else n_pass++;
    // exponent 1 is the smallest normal
    drive_word(1'b1, 24'h800000, 10'h001, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h80800000) $display("FAIL normal_emin_result: got %h expected 80800000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00000) $display("FAIL normal_emin_flags: got %b expected 00000", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b0) $display("FAIL normal_emin_inexact: got %b expected 0", bus.out_inexact); else n_pass++;
  endtask

  task automatic test_overflow();
    drive_word(1'b0, 24'hFFFFFF, 10'h0FE, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h7F7FFFFF) $display("FAIL ovf_emax_result: got %h expected 7f7fffff", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00000) $display("FAIL ovf_emax_flags: got %b expected 00000", bus.out_flags); else n_pass++;
    drive_word(1'b1, 24'h800000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'hFF800000) $display("FAIL ovf_edge_result: got %h expected ff800000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b01100) $display("FAIL ovf_edge_flags: got %b expected 01100", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b1) $display("FAIL ovf_edge_inexact: got %b expected 1", bus.out_inexact); else n_pass++;
    drive_word(1'b0, 24'hA00000, 10'h1FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h7F800000) $display("FAIL ovf_big_result: got %h expected 7f800000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b01100) $display("FAIL ovf_big_flags: got %b expected 01100", bus.out_flags); else n_pass++;
  endtask

  task automatic test_underflow();
    drive_word(1'b0, 24'h800000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h00000000) $display("FAIL unf_zero_e_result: got %h expected 00000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00011) $display("FAIL unf_zero_e_flags: got %b expected 00011", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b1) $display("FAIL unf_zero_e_inexact: got %b expected 1", bus.out_inexact); else n_pass++;
    drive_word(1'b0, 24'h800000, 10'h3F0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h00000000) $display("FAIL unf_neg_result: got %h expected 00000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00011) $display("FAIL unf_neg_flags: got %b expected 00011", bus.out_flags); else n_pass++;
    drive_word(1'b1, 24'h900000, 10'h3FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h80000000) $display("FAIL unf_sign_result: got %h expected 80000000", bus.out_result); else n_pass++;
    // zero mantissa is Zero (not Underflow) and masks in_inexact
    drive_word(1'b0, 24'h000000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.out_result !== 32'h00000000) $display("FAIL zero_m_result: got %h expected 00000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00001) $display("FAIL zero_m_flags: got %b expected 00001", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b0) $display("FAIL zero_m_inexact: got %b expected 0", bus.out_inexact); else n_pass++;
    drive_word(1'b1, 24'h000000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.out_result !== 32'h80000000) $display("FAIL zero_over_ovf_result: got %h expected 80000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00001) $display("FAIL zero_over_ovf_flags: got %b expected 00001", bus.out_flags); else n_pass++;
    drive_word(1'b0, 24'hC00000, 10'h07F, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.out_result !== 32'h00000000) $display("FAIL zero_flag_result: got %h expected 00000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00001) $display("FAIL zero_flag_flags: got %b expected 00001", bus.out_flags); else n_pass++;
  endtask

  task automatic test_priority();
    drive_idle();
    step();
    step();
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    drive_word(1'b1, 24'hC00000, 10'h0FF, 1'b0, 1'b1, 1'b1, 1'b1);
    step();
    n_checks++; if (bus.out_result !== 32'h7FC00000) $display("FAIL nan_result: got %h expected 7fc00000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b10000) $display("FAIL nan_flags: got %b expected 10000", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b0) $display("FAIL nan_inexact: got %b expected 0", bus.out_inexact); else n_pass++;
    drive_word(1'b1, 24'h800000, 10'h3F0, 1'b1, 1'b1, 1'b0, 1'b1);
    step();
    n_checks++; if (bus.out_result !== 32'hFF800000) $display("FAIL inf_result: got %h expected ff800000", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b01000) $display("FAIL inf_flags: got %b expected 01000", bus.out_flags); else n_pass++;
    n_checks++; if (bus.out_inexact !== 1'b0) $display("FAIL inf_inexact: got %b expected 0", bus.out_inexact); else n_pass++;
    drive_idle();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bubble_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_result !== 32'hFF800000) $display("FAIL bubble_hold_result: got %h expected ff800000", bus.out_result); else n_pass++;
    n_checks++; if (bus.sticky_flags !== (STICKY_EN ? 5'b10000 : 5'b00000)) $display("FAIL sticky_invalid: got %b expected %b", bus.sticky_flags, (STICKY_EN ? 5'b10000 : 5'b00000)); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [RES_W-1:0] tbl [4];
    logic [EXP_W+1:0] e_tbl [4];
    logic [RES_W-1:0] got;
    int idx;
    int seen;
    int cyc;
    tbl[0] = 32'h08000000; e_tbl[0] = 10'h010;
    tbl[1] = 32'h10000000; e_tbl[1] = 10'h020;
    tbl[2] = 32'h18000000; e_tbl[2] = 10'h030;
    tbl[3] = 32'h20000000; e_tbl[3] = 10'h040;
    idx = 0; seen = 0; cyc = 0;
    exp_q.delete();
    drive_idle();
    step();
    while ((idx < 4 || exp_q.size() != 0) && cyc < 40) begin
      bus.out_ready = !(cyc >= 1 && cyc <= 3);
      if (idx < 4) drive_word(1'b0, 24'h800000, e_tbl[idx], 1'b0, 1'b0, 1'b0, 1'b0);
      else drive_idle();
      #1;
      if (!bus.out_ready) begin
        n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0 (cycle %0d)", bus.in_ready, cyc); else n_pass++;
        if (exp_q.size() != 0) begin
          n_checks++; if (bus.out_result !== exp_q[0]) $display("FAIL stall_hold_result: got %h expected %h", bus.out_result, exp_q[0]); else n_pass++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL drain_spurious: got %h expected no word", bus.out_result);
        else begin
          got = exp_q.pop_front();
          seen++;
          if (bus.out_result !== got) $display("FAIL drain_order: got %h expected %h", bus.out_result, got); else n_pass++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(tbl[idx]);
        idx++;
      end
      cyc++;
      step();
    end
    n_checks++; if (seen !== 4 || cyc >= 40) $display("FAIL drain_count: got %0d words in %0d cycles expected 4 within 40", seen, cyc); else n_pass++;
    bus.out_ready = 1'b1;
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid_stall();
    bus.out_ready = 1'b0;
    drive_word(1'b0, 24'hC00000, 10'h07F, 1'b0, 1'b0, 1'b1, 1'b0);
    step();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL midstall_setup: got valid=%b ready=%b expected valid=1 ready=0", bus.out_valid, bus.in_ready); else n_pass++;
    rst_n = 1'b0;
    drive_idle();
    step();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midstall_rst_valid: got %b expected 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_result !== 32'h0) $display("FAIL midstall_rst_result: got %h expected 00000000", bus.out_result); else n_pass++;
    n_checks++; if (bus.sticky_flags !== 5'b0) $display("FAIL midstall_rst_sticky: got %b expected 00000", bus.sticky_flags); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL midstall_rst_in_ready: got %b expected 1", bus.in_ready); else n_pass++;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_sticky();
    drive_word(1'b0, 24'h800000, 10'h0FF, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    drive_word(1'b0, 24'h800000, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    n_checks++; if (bus.sticky_flags !== (STICKY_EN ? 5'b01010 : 5'b00000)) $display("FAIL sticky_ovf: got %b expected %b", bus.sticky_flags, (STICKY_EN ? 5'b01010 : 5'b00000)); else n_pass++;
    drive_idle();
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    n_checks++; if (bus.sticky_flags !== (STICKY_EN ? 5'b00111 : 5'b00000)) $display("FAIL sticky_clr_and_or: got %b expected %b", bus.sticky_flags, (STICKY_EN ? 5'b00111 : 5'b00000)); else n_pass++;
    n_checks++; if (bus.out_flags !== 5'b00011) $display("FAIL sticky_last_flags: got %b expected 00011", bus.out_flags); else n_pass++;
    bus.clr_sticky = 1'b1;
    step();
    bus.clr_sticky = 1'b0;
    n_checks++; if (bus.sticky_flags !== 5'b00000) $display("FAIL sticky_clr_only: got %b expected 00000", bus.sticky_flags); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.out_ready  = 1'b1;
    bus.clr_sticky = 1'b0;
    drive_idle();
    @(negedge clk);
    test_reset();
    test_normal();
    test_overflow();
    test_underflow();
    test_priority();
    test_backpressure();
    test_reset_mid_stall();
    test_sticky();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fp_result_flag_unit.md
# fp_result_flag_unit

Parametrised result-classification and exception-flag stage for the FPU datapath, placed after the multiplier's normalise/round stage. It classifies each rounded result as NaN, infinity, overflow, underflow (flush-to-zero), zero or normal, packs the final IEEE-754 word, and registers it behind a valid/ready handshake. It also keeps a sticky exception-flag accumulator for the FPU status logic. The block generalises the multiplier's single registered zero flag to arbitrary exponent/mantissa widths with a full flag set.

## Interface
Parameters:
- EXP_W, 8, biased exponent width of the packed result
- MAN_W, 24, mantissa width including the hidden bit

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-low
- in_valid  in  1  input result valid
- in_ready  out  1  stage can accept input
- res_s  in  1  result sign
- res_m  in  MAN_W  normalised, rounded mantissa (hidden bit at MSB)
- res_e  in  EXP_W+2  biased exponent, two's complement, before range check
- initial_zero_flag, initial_inf_flag, initial_nan_flag  in  1 each  special-operand decode from the front end
- in_inexact  in  1  rounding discarded nonzero bits
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_result  out  EXP_W+MAN_W  packed IEEE word {s, e, frac}
- out_flags  out  5  {nan, inf, overflow, underflow, zero}
- out_inexact  out  1  inexact for this result
- clr_sticky  in  1  clear sticky accumulator
- sticky_flags  out  5  {invalid, overflow, underflow, inexact, zero}

## Operation
- Class is decided combinationally from the inputs, with strict priority:
  - NaN: initial_nan_flag.
  - Inf: initial_inf_flag.
  - Zero: initial_zero_flag, or res_m == 0.
  - Overflow: signed res_e >= 2^EXP_W − 1.
  - Underflow: signed res_e <= 0.
  - Normal: otherwise.
- Packing per class:
  - NaN → canonical quiet NaN: sign 0, exponent all ones, frac MSB 1, remaining frac bits 0.
  - Inf → {res_s, all ones, 0}.
  - Overflow → {res_s, all ones, 0}.
  - Zero → {res_s, 0, 0}.
  - Underflow → {res_s, 0, 0} (flush-to-zero, no subnormals).
  - Normal → {res_s, res_e[EXP_W-1:0], res_m[MAN_W-2:0]}.
- out_flags per class:
  - nan = NaN class.
  - inf = Inf or Overflow class.
  - overflow = Overflow class.
  - underflow = Underflow class.
  - zero = Zero or Underflow class.
  - Exactly one of NaN, Inf, Overflow, Underflow, Zero, Normal is active per result.
- out_inexact = (Overflow | Underflow) | (Normal & in_inexact). It is 0 for the NaN, Inf and Zero classes.
- Handshake:
  - One output register stage.
  - in_ready = out_ready | ~out_valid.
  - Transfer occurs when in_valid & in_ready.
  - The output holds stable while out_valid & ~out_ready.
- Sticky accumulator: on each output-side transfer (out_valid & out_ready), OR the accepted word's flags into sticky_flags. The invalid bit is taken from nan.

## Timing
- Latency 1 cycle: input accepted on edge N appears on out_* after edge N.
- Throughput 1 per cycle while out_ready is high.
- Reset (RST low at an edge):
  - out_valid = 0, out_result = 0, out_flags = 0, out_inexact = 0, sticky_flags = 0.
  - in_ready = 1 combinationally after reset.
  - A word held mid-stall is discarded.
- Bubble: if no input transfers while out_ready is high, out_valid drops to 0. out_result and out_flags keep their last value.
- Simultaneous clr_sticky and output transfer in the same cycle: sticky_flags becomes exactly the transferring word's flags (clear first, then OR).
- res_e boundaries:
  - 2^EXP_W − 2 is Normal.
  - 2^EXP_W − 1 and above is Overflow.
  - 1 is Normal.
  - 0 and negative values are Underflow.
- res_m == 0 with any res_e is Zero, not Underflow.

## Configuration
- FPU_STICKY_FLAGS_EN defined: the accumulator and clr_sticky are implemented as described above.
- FPU_STICKY_FLAGS_EN undefined: sticky_flags is tied to 0 and clr_sticky is ignored. The datapath and handshake are unchanged.

## Structure
- Shared package fpu_pkg holds:
  - Flag index constants (FLG_NAN, FLG_INF, FLG_OVF, FLG_UNF, FLG_ZERO and the sticky bit indices).
  - The class enum (CLS_NAN, CLS_INF, CLS_OVF, CLS_UNF, CLS_ZERO, CLS_NORM).
  - The canonical-NaN construction constant.
- One sub-module, fp_result_classify: purely combinational class, pack and flag generation. The top level holds the register stage, handshake and sticky accumulator.

## Test plan
Defaults EXP_W=8, MAN_W=24; out_ready=1 unless stated.
- Normal: res_e=0x07F, res_m=0xC00000, s=0 → out_result=0x3FC00000, out_flags=0, out_inexact = in_inexact, one cycle later.
- Overflow boundary:
  - res_e=0x0FE → 0x7F7FFFFF for res_m=0xFFFFFF, Normal.
  - res_e=0x0FF, s=1 → 0xFF800000, flags inf|overflow, inexact=1.
- Underflow: res_e=0x000 then 0x3F0 (negative), res_m=0x800000 → 0x00000000, flags underflow|zero, inexact=1. res_m=0, res_e=0 → zero flag only, inexact=0.
- Priority: initial_nan_flag=1 with initial_inf_flag=1 and res_e=0x0FF → 0x7FC00000, flags nan only. Sticky invalid bit sets after transfer.
- Backpressure: out_ready low for 3 cycles with in_valid high → in_ready=0, out_result held, then words drain in order with no loss or duplication. RST low mid-stall → out_valid=0 next cycle, sticky_flags=0.
- Sticky: an overflow word, then clr_sticky asserted in the same cycle as an underflow word transfers → sticky_flags = {underflow, inexact, zero} only. Without FPU_STICKY_FLAGS_EN → sticky_flags stays 0.
